// File: rtl/parallel_bus_master_if.sv
// Handshake and pin bundle for parallel_bus_master.
// master: the controller's view; slave: the sequencer/pad-side view.
interface parallel_bus_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CS_NUM     = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int TIM_WIDTH  = 8
);
    localparam int CS_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;

    // Command side
    logic                  start;
    logic                  wr_cmd;
    logic [CS_W-1:0]       cs_sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  wide;
    logic [TIM_WIDTH-1:0]  t_setup;
    logic [TIM_WIDTH-1:0]  t_strobe;
    logic [TIM_WIDTH-1:0]  t_hold;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  busy;
    logic                  done;

    // Device pins
    logic                  pwd;
    logic [CS_NUM-1:0]     p_cs_n;
    logic                  p_wr_n;
    logic                  p_rd_n;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_wdata;
    logic [DATA_WIDTH-1:0] p_rdata;
    logic                  p_oe;

    modport master (
        input  start, wr_cmd, cs_sel, addr, burst_len, wide,
               t_setup, t_strobe, t_hold, wdata, wdata_valid, p_rdata,
        output wdata_ready, rdata, rdata_valid, busy, done,
               pwd, p_cs_n, p_wr_n, p_rd_n, p_addr, p_wdata, p_oe
    );

    modport slave (
        output start, wr_cmd, cs_sel, addr, burst_len, wide,
               t_setup, t_strobe, t_hold, wdata, wdata_valid, p_rdata,
        input  wdata_ready, rdata, rdata_valid, busy, done,
               pwd, p_cs_n, p_wr_n, p_rd_n, p_addr, p_wdata, p_oe
    );
endinterface

// File: rtl/parallel_bus_master.sv
// Burst master for parallel-port devices with programmable setup/strobe/hold.
// Optional feature macro PARALLEL_BUS_ADDR_INC_EN: when defined, p_addr
// advances by one per word (linear burst); otherwise it stays fixed
// (FIFO-style data register).
module parallel_bus_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CS_NUM     = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int TIM_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    parallel_bus_master_if.master bus
);
    localparam int CS_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;
    localparam logic [DATA_WIDTH-1:0] LO_MASK = DATA_WIDTH'(8'hFF);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_STROBE, S_HOLD, S_NEXT
    } state_t;

    state_t                state_q, state_d;
    logic [TIM_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CS_W-1:0]       cs_q, cs_d;
    logic                  rd_q, rd_d;
    logic                  wide_q, wide_d;
    logic [TIM_WIDTH-1:0]  tset_q, tset_d;
    logic [TIM_WIDTH-1:0]  tstb_q, tstb_d;
    logic [TIM_WIDTH-1:0]  thld_q, thld_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvld_q, rvld_d;
    logic                  done_q, done_d;
    logic [CS_NUM-1:0]     cs_n;

    // A phase of length t counts down from t-1; zero means one cycle.
    function automatic logic [TIM_WIDTH-1:0] phase_load(input logic [TIM_WIDTH-1:0] t);
        return (t == '0) ? '0 : t - TIM_WIDTH'(1);
    endfunction

    // 8-bit port mode clears the upper byte.
    function automatic logic [DATA_WIDTH-1:0] port_mask(input logic [DATA_WIDTH-1:0] d,
                                                        input logic w);
        return w ? d : (d & LO_MASK);
    endfunction

    // State and datapath registers; every field returns to its idle value on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            cs_q     <= '0;
            rd_q     <= 1'b0;
            wide_q   <= 1'b0;
            tset_q   <= '0;
            tstb_q   <= '0;
            thld_q   <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            rd_q     <= rd_d;
            wide_q   <= wide_d;
            tset_q   <= tset_d;
            tstb_q   <= tstb_d;
            thld_q   <= thld_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            rvld_q   <= rvld_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: phase sequencing, word counting and data capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        cs_d     = cs_q;
        rd_d     = rd_q;
        wide_d   = wide_q;
        tset_d   = tset_q;
        tstb_d   = tstb_q;
        thld_d   = thld_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        rvld_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rd_d   = bus.wr_cmd;
                    cs_d   = (int'(bus.cs_sel) >= CS_NUM) ? '0 : bus.cs_sel;
                    addr_d = bus.addr;
                    rem_d  = (bus.burst_len == '0) ? LEN_WIDTH'(1) : bus.burst_len;
                    wide_d = bus.wide;
                    tset_d = bus.t_setup;
                    tstb_d = bus.t_strobe;
                    thld_d = bus.t_hold;
                    cnt_d  = phase_load(bus.t_setup);
                    state_d = bus.wr_cmd ? S_SETUP : S_WDATA;
                end
            end
            S_WDATA: begin
                if (bus.wdata_valid) begin
                    pwdata_d = port_mask(bus.wdata, wide_q);
                    cnt_d    = phase_load(tset_q);
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = phase_load(tstb_q);
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - TIM_WIDTH'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    // Read data is captured on the last strobe cycle.
                    if (rd_q) begin
                        rdata_d = port_mask(bus.p_rdata, wide_q);
                        rvld_d  = 1'b1;
                    end
                    cnt_d   = phase_load(thld_q);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - TIM_WIDTH'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q - TIM_WIDTH'(1);
                end
            end
            S_NEXT: begin
                rem_d = rem_q - LEN_WIDTH'(1);
`ifdef PARALLEL_BUS_ADDR_INC_EN
                addr_d = addr_q + ADDR_WIDTH'(1);
`endif
                if (rem_q == LEN_WIDTH'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (rd_q) begin
                    cnt_d   = phase_load(tset_q);
                    state_d = S_SETUP;
                end else begin
                    state_d = S_WDATA;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Chip select: exactly the latched device is active while a burst runs.
    always_comb begin
        cs_n = '1;
        if (state_q != S_IDLE) cs_n[cs_q] = 1'b0;
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.wdata_ready = (state_q == S_WDATA);
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvld_q;
    assign bus.pwd         = wide_q;
    assign bus.p_cs_n      = cs_n;
    assign bus.p_wr_n      = !((state_q == S_STROBE) && !rd_q);
    assign bus.p_rd_n      = !((state_q == S_STROBE) && rd_q);
    assign bus.p_addr      = addr_q;
    assign bus.p_wdata     = pwdata_q;
    assign bus.p_oe        = (state_q != S_IDLE) && !rd_q;
endmodule

// File: tb/tb_parallel_bus_master.sv
// Scoreboard bench for parallel_bus_master: expected port writes and read
// words are queued when a burst is issued and popped as the pins/rdata show them.
module tb_parallel_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    parallel_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .CS_NUM(2),
                             .LEN_WIDTH(8), .TIM_WIDTH(8)) bus ();

    parallel_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .CS_NUM(2),
                          .LEN_WIDTH(8), .TIM_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device model: read data reflects the address presented.
    assign bus.p_rdata = 16'h1000 + {8'h00, bus.p_addr};

`ifdef PARALLEL_BUS_ADDR_INC_EN
    localparam bit INC = 1'b1;
`else
    localparam bit INC = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    wr_t         e_wr;
    logic [15:0] e_rd;

    int n_checks = 0;
    int n_pass   = 0;

    // Expectations for the burst in flight, set by the stimulus.
    int          exp_stb = 1;
    logic [1:0]  exp_csn = 2'b11;
    logic        exp_pwd = 1'b0;

    int wr_low = 0, rd_low = 0;
    int wr_pulses = 0, rd_pulses = 0, rvld_cnt = 0, done_cnt = 0;
    int acc_cyc = 0, start_cyc = 0, done_at = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] exp_addr(input logic [7:0] base, input int i);
        logic [7:0] step;
        step = 8'(i);
        return base + (INC ? step : 8'd0);
    endfunction

    // Pin and read-data monitor.
    always @(negedge clk) begin
        if (!rst) begin
            wr_low = 0;
            rd_low = 0;
        end else begin
            if (!bus.p_wr_n) begin
                wr_low++;
                if (wr_low == 1) begin
                    wr_pulses++;
                    check_eq("wr_sb_has", 32'(exp_wr.size() != 0), 32'd1);
                    if (exp_wr.size() != 0) begin
                        e_wr = exp_wr.pop_front();
                        check_eq("wr_addr", 32'(bus.p_addr), 32'(e_wr.addr));
                        check_eq("wr_data", 32'(bus.p_wdata), 32'(e_wr.data));
                    end
                    check_eq("wr_cs", 32'(bus.p_cs_n), 32'(exp_csn));
                    check_eq("wr_oe", 32'(bus.p_oe), 32'd1);
                    check_eq("wr_pwd", 32'(bus.pwd), 32'(exp_pwd));
                end
            end else if (wr_low != 0) begin
                check_eq("wr_strobe_len", 32'(wr_low), 32'(exp_stb));
                wr_low = 0;
            end
            if (!bus.p_rd_n) begin
                rd_low++;
                if (rd_low == 1) begin
                    rd_pulses++;
                    check_eq("rd_cs", 32'(bus.p_cs_n), 32'(exp_csn));
                    check_eq("rd_oe", 32'(bus.p_oe), 32'd0);
                    check_eq("rd_pwd", 32'(bus.pwd), 32'(exp_pwd));
                end
            end else if (rd_low != 0) begin
                check_eq("rd_strobe_len", 32'(rd_low), 32'(exp_stb));
                rd_low = 0;
            end
            if (bus.rdata_valid) begin
                rvld_cnt++;
                check_eq("rd_sb_has", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) begin
                    e_rd = exp_rd.pop_front();
                    check_eq("rdata", 32'(bus.rdata), 32'(e_rd));
                end
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic check_reset_state();
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_wready", 32'(bus.wdata_ready), 32'd0);
        check_eq("rst_rvld", 32'(bus.rdata_valid), 32'd0);
        check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
        check_eq("rst_pwd", 32'(bus.pwd), 32'd0);
        check_eq("rst_cs_n", 32'(bus.p_cs_n), 32'h3);
        check_eq("rst_strobes", 32'({bus.p_wr_n, bus.p_rd_n}), 32'h3);
        check_eq("rst_addr", 32'(bus.p_addr), 32'd0);
        check_eq("rst_wdata", 32'(bus.p_wdata), 32'd0);
        check_eq("rst_oe", 32'(bus.p_oe), 32'd0);
    endtask

    task automatic start_burst(input logic rd, input logic cs, input logic [7:0] a,
                               input logic [7:0] len, input logic w,
                               input logic [7:0] ts, input logic [7:0] tst, input logic [7:0] th);
        @(negedge clk);
        bus.wr_cmd = rd; bus.cs_sel = cs; bus.addr = a; bus.burst_len = len;
        bus.wide = w; bus.t_setup = ts; bus.t_strobe = tst; bus.t_hold = th;
        bus.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic give_word(input logic [15:0] d, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.wdata_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("wready_seen", 32'(bus.wdata_ready), 32'd1);
        for (int k = 0; k < stall; k++) begin
            check_eq("stall_ready", 32'(bus.wdata_ready), 32'd1);
            check_eq("stall_strobes", 32'({bus.p_wr_n, bus.p_rd_n}), 32'h3);
            check_eq("stall_cs", 32'(bus.p_cs_n), 32'(exp_csn));
            @(negedge clk);
        end
        bus.wdata = d;
        bus.wdata_valid = 1'b1;
        acc_cyc = cyc;
        @(posedge clk);
        #1 bus.wdata_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 32'(bus.done), 32'd1);
        done_at = cyc;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, p0, r0, seen;
        logic prev;
        bus.start = 0; bus.wr_cmd = 0; bus.cs_sel = 0; bus.addr = 0; bus.burst_len = 0;
        bus.wide = 0; bus.t_setup = 0; bus.t_strobe = 0; bus.t_hold = 0;
        bus.wdata = 0; bus.wdata_valid = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b1;

        // Single 8-bit write, t = 2/3/1
        exp_stb = 3; exp_csn = 2'b10; exp_pwd = 1'b0;
        exp_wr.push_back('{addr: 8'h10, data: 16'h00A5});
        d0 = done_cnt; p0 = wr_pulses;
        start_burst(1'b0, 1'b0, 8'h10, 8'd1, 1'b0, 8'd2, 8'd3, 8'd1);
        give_word(16'hFFA5, 0);
        wait_done();
        check_eq("w1_done_latency", 32'(done_at - acc_cyc), 32'd8);
        check_eq("w1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_eq("w1_wr_pulses", 32'(wr_pulses - p0), 32'd1);
        check_eq("w1_idle_cs", 32'(bus.p_cs_n), 32'h3);

        // 16-bit read burst of 4 on device 1
        exp_stb = 2; exp_csn = 2'b01; exp_pwd = 1'b1;
        for (int i = 0; i < 4; i++) exp_rd.push_back(16'h1000 + {8'h00, exp_addr(8'h20, i)});
        r0 = rvld_cnt; p0 = rd_pulses;
        start_burst(1'b1, 1'b1, 8'h20, 8'd4, 1'b1, 8'd1, 8'd2, 8'd1);
        wait_done();
        check_eq("r4_rvld_cnt", 32'(rvld_cnt - r0), 32'd4);
        check_eq("r4_rd_pulses", 32'(rd_pulses - p0), 32'd4);
        check_eq("r4_sb_empty", 32'(exp_rd.size()), 32'd0);

        // Write burst of 3 with a 5-cycle stall before word 2
        exp_stb = 1; exp_csn = 2'b10; exp_pwd = 1'b1;
        exp_wr.push_back('{addr: exp_addr(8'h40, 0), data: 16'h1111});
        exp_wr.push_back('{addr: exp_addr(8'h40, 1), data: 16'h2222});
        exp_wr.push_back('{addr: exp_addr(8'h40, 2), data: 16'h3333});
        p0 = wr_pulses;
        start_burst(1'b0, 1'b0, 8'h40, 8'd3, 1'b1, 8'd1, 8'd1, 8'd1);
        give_word(16'h1111, 0);
        give_word(16'h2222, 5);
        give_word(16'h3333, 0);
        wait_done();
        check_eq("wstall_wr_pulses", 32'(wr_pulses - p0), 32'd3);
        check_eq("wstall_sb_empty", 32'(exp_wr.size()), 32'd0);

        // Zero timing fields and zero length, 8-bit read
        exp_stb = 1; exp_csn = 2'b10; exp_pwd = 1'b0;
        exp_rd.push_back(16'h0033);
        r0 = rvld_cnt;
        start_burst(1'b1, 1'b0, 8'h33, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0);
        wait_done();
        check_eq("z_done_latency", 32'(done_at - start_cyc), 32'd5);
        check_eq("z_rvld_cnt", 32'(rvld_cnt - r0), 32'd1);

        // Address wrap, 3 reads from 0xFE
        exp_stb = 1; exp_csn = 2'b10; exp_pwd = 1'b1;
        for (int i = 0; i < 3; i++) exp_rd.push_back(16'h1000 + {8'h00, exp_addr(8'hFE, i)});
        start_burst(1'b1, 1'b0, 8'hFE, 8'd3, 1'b1, 8'd1, 8'd1, 8'd1);
        wait_done();
        check_eq("wrap_sb_empty", 32'(exp_rd.size()), 32'd0);

        // Reset during the strobe of word 2
        exp_stb = 2; exp_csn = 2'b10; exp_pwd = 1'b1;
        for (int i = 0; i < 4; i++) exp_rd.push_back(16'h1000 + {8'h00, exp_addr(8'h50, i)});
        start_burst(1'b1, 1'b0, 8'h50, 8'd4, 1'b1, 8'd1, 8'd2, 8'd1);
        seen = 0; prev = 1'b1;
        for (int n = 0; n < 200 && seen < 2; n++) begin
            @(negedge clk);
            if (prev && !bus.p_rd_n) seen++;
            prev = bus.p_rd_n;
        end
        check_eq("rst_reached_word2", 32'(seen), 32'd2);
        #1 rst = 1'b0;
        #1 check_reset_state();
        check_eq("rst_sb_left", 32'(exp_rd.size()), 32'd3);
        exp_rd.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("rst_idle_busy", 32'(bus.busy), 32'd0);

        // Normal burst after reset: 2-word write on device 1
        exp_stb = 1; exp_csn = 2'b01; exp_pwd = 1'b1;
        exp_wr.push_back('{addr: exp_addr(8'h60, 0), data: 16'hBEEF});
        exp_wr.push_back('{addr: exp_addr(8'h60, 1), data: 16'hCAFE});
        p0 = wr_pulses; d0 = done_cnt;
        start_burst(1'b0, 1'b1, 8'h60, 8'd2, 1'b1, 8'd1, 8'd1, 8'd1);
        give_word(16'hBEEF, 0);
        give_word(16'hCAFE, 0);
        wait_done();
        check_eq("post_wr_pulses", 32'(wr_pulses - p0), 32'd2);
        check_eq("post_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_eq("post_sb_empty", 32'(exp_wr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/parallel_bus_master.md
Name: parallel_bus_master

Overview:
- Parametrised successor to the single-word parallel register port controller.
- Runs burst reads/writes of 1..2^LEN_WIDTH-1 words to one of CS_NUM parallel-port devices, selectable per burst.
- Setup/strobe/hold timing is programmable at run time; 8- or 16-bit port mode; valid/ready word handshake.
- Sits between the control sequencer and the device pins; the top level builds the tristate pad from p_oe.

Parameters:
- ADDR_WIDTH, 8, device address width.
- DATA_WIDTH, 16, port data width; must be 8 or 16.
- CS_NUM, 2, number of chip selects.
- LEN_WIDTH, 8, burst length counter width.
- TIM_WIDTH, 8, width of each timing field, in clk cycles.

Ports:
- clk  in  1  main clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- wr_cmd  in  1  0 = write, 1 = read.
- cs_sel  in  log2(CS_NUM) (min 1)  target device index.
- addr  in  ADDR_WIDTH  start address.
- burst_len  in  LEN_WIDTH  word count; 0 is treated as 1.
- wide  in  1  1 = 16-bit port, 0 = 8-bit; drives pwd.
- t_setup, t_strobe, t_hold  in  TIM_WIDTH each  phase lengths in cycles; 0 is treated as 1.
- wdata  in  DATA_WIDTH  write word.
- wdata_valid  in  1  write word available.
- wdata_ready  out  1  write word accepted when valid&ready.
- rdata  out  DATA_WIDTH  read word.
- rdata_valid  out  1  one-cycle pulse per read word.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- pwd  out  1  port width pin.
- p_cs_n  out  CS_NUM  active-low chip selects.
- p_wr_n, p_rd_n  out  1 each  active-low strobes.
- p_addr  out  ADDR_WIDTH  port address.
- p_wdata  out  DATA_WIDTH  port write data.
- p_rdata  in  DATA_WIDTH  port read data.
- p_oe  out  1  1 = FPGA drives the data bus.

Behaviour:
- Reset values, applied immediately on rst low, including mid-burst:
  - busy=0, done=0, wdata_ready=0, rdata_valid=0, rdata=0, pwd=0.
  - p_cs_n all 1, p_wr_n=1, p_rd_n=1, p_addr=0, p_wdata=0, p_oe=0.
  - FSM goes to IDLE.
- IDLE:
  - On start, latch wr_cmd, cs_sel, addr, burst_len, wide and the three timing fields.
  - Set busy=1.
  - Go to WDATA for a write, or SETUP for a read.
  - start while busy is ignored.
- WDATA (write only):
  - wdata_ready=1; the FSM waits indefinitely for wdata_valid.
  - On valid&ready, register wdata into p_wdata, drop ready, go to SETUP.
  - In 8-bit mode, p_wdata[15:8] is forced to 0.
- SETUP:
  - Selected p_cs_n=0, p_addr driven, strobes high.
  - p_oe = ~wr_cmd.
  - Lasts t_setup cycles.
- STROBE:
  - p_wr_n=0 (write) or p_rd_n=0 (read) for t_strobe cycles.
  - Read: p_rdata is sampled on the last STROBE cycle. rdata and rdata_valid=1 appear the next cycle, valid for one cycle.
  - In 8-bit mode, rdata[15:8]=0.
- HOLD:
  - Strobe high; cs, addr and p_oe held for t_hold cycles.
- NEXT:
  - Decrement the remaining count and update the address per the optional feature.
  - If the count is nonzero, go to WDATA (write) or SETUP (read).
  - Otherwise deassert p_cs_n, set p_oe=0, busy=0, pulse done=1, and return to IDLE.
- NEXT costs one cycle. Per-word time is t_setup+t_strobe+t_hold+1 cycles, plus any WDATA wait for writes.
- The address counter wraps modulo 2^ADDR_WIDTH; no error is raised.
- burst_len=0 runs exactly one word.
- Phase counters are TIM_WIDTH wide and reload on every phase entry.
- Exactly one p_cs_n bit is low during a burst. A cs_sel value >= CS_NUM selects device 0.

Optional Feature:
- Macro: PARALLEL_BUS_ADDR_INC_EN.
- Defined: p_addr increments by 1 in each NEXT state, giving a linear burst.
- Undefined: p_addr stays fixed for the whole burst, for FIFO-style data registers. The increment logic is removed.

Test Plan:
- Write, wide=0, addr=0x10, len=1, t=2/3/1: one word 0xA5 goes out. p_wr_n is low for exactly 3 cycles; p_wdata=0x00A5; p_oe=1; done pulses once, 8 cycles after acceptance.
- Read, wide=1, cs_sel=1, addr=0x20, len=4, p_rdata returns 0x1000+addr:
  - Four rdata_valid pulses.
  - With the macro: values 0x1020..0x1023.
  - Without the macro: four 0x1020 reads at a constant p_addr.
  - Only p_cs_n[1] goes low; p_oe=0 throughout.
- Write burst len=3 with wdata_valid withheld 5 cycles before word 2: the FSM stalls in WDATA with strobes high and cs low. Burst resumes; three p_wr_n pulses total.
- Timing fields all 0: every phase lasts 1 cycle; a read word completes in 4 cycles.
- Address wrap: addr=0xFE, len=3, macro defined -> p_addr sequence 0xFE, 0xFF, 0x00.
- Assert rst during STROBE of word 2 -> outputs take their reset values immediately; no done pulse. A new start after reset runs a normal burst.
